// File: rtl/div_pkg.sv
// Shared types and helpers for the shared iterative divider: FSM states,
// default sizing and the round-robin grant picker.
package div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... mod nreq; the downward loop lets the closest hit win.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                    input int ptr, input int nreq);
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_NREQ-1; i >= 0; i--) begin
      if (i < nreq) begin
        k = ptr + i;
        if (k >= nreq) k = k - nreq;
        if (valid[k[5:0]]) begin
          p.found = 1'b1;
          p.idx   = 6'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/div_share_arbiter_core.sv
// One-bit-per-cycle restoring divider. q/r present the result of the step
// being taken this cycle, so on the final step they are the finished result.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q, b_q, rem;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   sh, trial;

  // rem stays below b between steps, so its top bit only exists transiently in sh
  always_comb begin
    sh    = {rem, a_q[WIDTH-1]};
    trial = sh - {1'b0, b_q};
    q     = {a_q[WIDTH-2:0], ~trial[WIDTH]};
    r     = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  assign done = run && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      a_q <= a;
      b_q <= b;
      rem <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      a_q <= q;
      rem <= r;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one iterative divider across NREQ clients,
// with a single held response channel.
module div_share_arbiter
  import div_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_A,
  input  logic [NREQ*WIDTH-1:0] req_B,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_Q,
  output logic [WIDTH-1:0]      rsp_R,
  output logic                  rsp_dz,
  output logic                  busy
);

  state_t                       state, state_n;
  logic [IDW-1:0]               rr_ptr, cur_id, grant;
  logic [NREQ-1:0][WIDTH-1:0]   a_arr, b_arr;
  logic [MAX_NREQ-1:0]          valid_ext;
  pick_t                        pick;
  logic                         accept, b_zero, core_done;
  logic [WIDTH-1:0]             a_sel, b_sel, core_q, core_r;

  assign a_arr     = req_A;
  assign b_arr     = req_B;
  assign valid_ext = MAX_NREQ'(req_valid);
  assign pick      = rr_pick(valid_ext, int'(rr_ptr), NREQ);
  assign grant     = IDW'(pick.idx);
  assign a_sel     = a_arr[grant];
  assign b_sel     = b_arr[grant];
  assign b_zero    = (b_sel == '0);

  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: if (pick.found) begin
        accept           = 1'b1;
        req_ready[grant] = 1'b1;
        state_n          = b_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN:  if (core_done) state_n = ST_DONE;
      ST_DONE: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // divide-by-zero never starts the core; the response is formed at accept
  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !b_zero),
    .a     (a_sel),
    .b     (b_sel),
    .done  (core_done),
    .q     (core_q),
    .r     (core_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      rsp_id <= '0;
      rsp_Q  <= '0;
      rsp_R  <= '0;
      rsp_dz <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
        cur_id <= grant;
        if (b_zero) begin
          rsp_id <= grant;
          rsp_Q  <= '1;
          rsp_R  <= a_sel;
          rsp_dz <= 1'b1;
        end
      end
      if (state == ST_RUN && core_done) begin
        rsp_id <= cur_id;
        rsp_Q  <= core_q;
        rsp_R  <= core_r;
        rsp_dz <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized + directed bench: a negedge monitor predicts grants, latency and
// results from plain arithmetic and scoreboards them against the DUT.
module tb_div_share_arbiter;
  localparam int W = 32, N = 4, IDW = 2;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [N*W-1:0] req_A = '0, req_B = '0;
  logic           rsp_valid, rsp_ready = 1'b1, rsp_dz, busy;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_Q, rsp_R;

  div_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_Q(rsp_Q), .rsp_R(rsp_R), .rsp_dz(rsp_dz), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [W-1:0] q, r;
    logic         dz;
  } exp_t;

  exp_t        sbq[$];
  exp_t        last_rsp;
  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  bit          m_busy = 0;
  int          m_ptr = 0;
  int unsigned m_due = 0;
  int          acc_cnt[N];
  int          acc_total = 0;
  int          dut_grants[$];
  logic [W-1:0] op_a[N], op_b[N];
  logic [N-1:0] vld = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_div(int id, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.id = id;
    if (b == 0) begin e.q = '1; e.r = a; e.dz = 1'b1; end
    else begin e.q = a / b; e.r = a % b; e.dz = 1'b0; end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + reference model: grant rule, latency and result, one decision per edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit           exp_valid;
    int           g, j;
    logic [W-1:0] a, b;
    if (rst) begin
      chk("reset rsp_valid", W'(rsp_valid), 0);
      chk("reset busy", W'(busy), 0);
      chk("reset req_ready", W'(req_ready), 0);
      chk("reset rsp_id", W'(rsp_id), 0);
      chk("reset rsp_Q", rsp_Q, 0);
      chk("reset rsp_R", rsp_R, 0);
      chk("reset rsp_dz", W'(rsp_dz), 0);
      sbq.delete();
      m_busy = 0;
      m_ptr = 0;
      last_rsp = '{0, 0, 0, 0};
    end else begin
      for (int k = 0; k < N; k++) if (req_ready[k]) dut_grants.push_back(k);
      exp_ready = '0;
      g = -1;
      if (!m_busy)
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_valid = m_busy && (cyc >= m_due);
      chk("req_ready", W'(req_ready), W'(exp_ready));
      chk("rsp_valid", W'(rsp_valid), W'(exp_valid));
      chk("busy", W'(busy), W'(m_busy));
      if (exp_valid && sbq.size() > 0) begin
        chk("rsp_id", W'(rsp_id), W'(sbq[0].id));
        chk("rsp_Q", rsp_Q, sbq[0].q);
        chk("rsp_R", rsp_R, sbq[0].r);
        chk("rsp_dz", W'(rsp_dz), W'(sbq[0].dz));
      end else if (!exp_valid) begin
        chk("hold rsp_id", W'(rsp_id), W'(last_rsp.id));
        chk("hold rsp_Q", rsp_Q, last_rsp.q);
        chk("hold rsp_R", rsp_R, last_rsp.r);
        chk("hold rsp_dz", W'(rsp_dz), W'(last_rsp.dz));
      end
      if (exp_valid && rsp_ready) begin
        last_rsp = sbq.pop_front();
        m_busy = 0;
      end else if (g >= 0) begin
        a = req_A[g*W +: W];
        b = req_B[g*W +: W];
        sbq.push_back(ref_div(g, a, b));
        m_ptr = (g + 1) % N;
        m_busy = 1;
        m_due = cyc + ((b == 0) ? 1 : W + 1);
        acc_cnt[g]++;
        acc_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_A[i*W +: W] = op_a[i];
      req_B[i*W +: W] = op_b[i];
    end
    req_valid = vld;
  endtask

  task automatic wait_total(input int target, input int budget, input string what);
    int t = 0;
    while (acc_total < target && t < budget) begin tick(); t++; end
    checks++;
    if (acc_total < target) begin
      errors++;
      $display("FAIL timeout %s: accepts %0d expected %0d", what, acc_total, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((m_busy || sbq.size() != 0) && t < budget) begin tick(); t++; end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL timeout idle: busy %0d expected 0", m_busy);
    end
  endtask

  task automatic one_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int tgt;
    tgt = acc_total + 1;
    op_a[i] = a; op_b[i] = b; vld[i] = 1'b1; drive();
    wait_total(tgt, 20, "single accept");
    vld[i] = 1'b0; op_a[i] = $urandom; op_b[i] = $urandom; drive();
    wait_idle(200);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk_grants(input string name, input int exp[]);
    chk({name, " count"}, W'(dut_grants.size()), W'(exp.size()));
    for (int k = 0; k < exp.size() && k < dut_grants.size(); k++)
      chk(name, W'(dut_grants[k]), W'(exp[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, seen[N];
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; acc_cnt[i] = 0; end
    drive();
    tick(); tick();
    rst = 1'b0;
    tick();

    // directed: single, divide by zero, edge operands (leaves rr pointer at 0)
    one_op(0, 100, 7);
    one_op(2, 32'h1234, 0);
    one_op(3, 32'hFFFF_FFFF, 1);
    one_op(3, 5, 9);
    one_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    one_op(3, 0, 5);

    // fairness: all valid, then only 1 and 3
    dut_grants.delete();
    for (int i = 0; i < N; i++) begin op_a[i] = rnd_val(); op_b[i] = rnd_val(); seen[i] = acc_cnt[i]; end
    vld = '1; drive();
    base = acc_total;
    for (int t = 0; t < 2000 && acc_total < base + 9; t++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          op_a[i] = rnd_val(); op_b[i] = rnd_val();
        end
      if (acc_total >= base + 6) vld = 4'b1010;
      drive();
    end
    vld = '0; drive();
    wait_idle(200);
    chk_grants("fair grant", '{0, 1, 2, 3, 0, 1, 3, 1, 3});

    // backpressure: result held, no new accept until handshake
    rsp_ready = 1'b0;
    base = acc_total;
    op_a[1] = 1000; op_b[1] = 3; vld[1] = 1'b1; drive();
    wait_total(base + 1, 20, "bp accept");
    vld[1] = 1'b0; op_a[2] = 77; op_b[2] = 0; vld[2] = 1'b1; drive();
    repeat (W + 6) tick();
    chk("bp no accept", W'(acc_total), W'(base + 1));
    rsp_ready = 1'b1;
    wait_total(base + 2, 4, "post-bp accept");
    vld[2] = 1'b0; drive();
    wait_idle(200);

    // random traffic with random backpressure
    for (int i = 0; i < N; i++) seen[i] = acc_cnt[i];
    base = acc_total;
    for (int t = 0; t < 20000 && acc_total < base + 120; t++) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          vld[i] = $urandom_range(0, 1);
          op_a[i] = rnd_val(); op_b[i] = rnd_val();
        end else if (!vld[i] && $urandom_range(0, 9) < 3) begin
          vld[i] = 1'b1;
          op_a[i] = rnd_val(); op_b[i] = rnd_val();
        end
      end
      drive();
    end
    chk("random accepts", W'(acc_total >= base + 120), 1);
    vld = '0; rsp_ready = 1'b1; drive();
    wait_idle(200);

    // reset in the middle of a run
    base = acc_total;
    op_a[0] = 32'hDEAD_BEEF; op_b[0] = 3; vld[0] = 1'b1; drive();
    wait_total(base + 1, 20, "pre-reset accept");
    vld[0] = 1'b0; drive();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (W + 4) tick();
    dut_grants.delete();
    base = acc_total;
    op_a[0] = 50; op_b[0] = 6; op_a[1] = 60; op_b[1] = 7; vld = 4'b0011; drive();
    wait_total(base + 1, 20, "post-reset accept 0");
    vld[0] = 1'b0; drive();
    wait_total(base + 2, 200, "post-reset accept 1");
    vld = '0; drive();
    wait_idle(200);
    chk_grants("post-reset grant", '{0, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
